// File: rtl/svm_block_dot.sv
// rtl/svm_block_dot.sv - 36-tap HOG block x linear-SVM weight dot product, serial weight fetch
// Optional macro SVM_BIAS_EN adds a bias input preloaded into the accumulator at accept.
module svm_block_dot #(
   parameter int FEA_I = 4,
   parameter int FEA_F = 28,
   parameter int BID_W = 13,
   parameter int W_I   = 4,
   parameter int W_F   = 12,
   parameter int ACC_W = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [9*(FEA_I+FEA_F)-1:0]        fea_a,
   input  logic [9*(FEA_I+FEA_F)-1:0]        fea_b,
   input  logic [9*(FEA_I+FEA_F)-1:0]        fea_c,
   input  logic [9*(FEA_I+FEA_F)-1:0]        fea_d,
   input  logic [BID_W-1:0]                  bid,
   input  logic                              i_valid,
   output logic                              i_ready,
   output logic                              w_ren,
   output logic [BID_W+5:0]                  w_addr,
   input  logic signed [W_I+W_F-1:0]         w_rdata,
   output logic signed [ACC_W-1:0]           dot,
   output logic [BID_W-1:0]                  o_bid,
   output logic                              o_valid,
   input  logic                              o_ready
`ifdef SVM_BIAS_EN
   ,
   input  logic signed [ACC_W-1:0]           bias
`endif
);

   localparam int FW = FEA_I + FEA_F;
   localparam int WW = W_I + W_F;
   localparam int PW = FW + WW + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]              state;
   logic [FW-1:0]           fea_q [0:35];
   logic [BID_W-1:0]        bid_q;
   logic signed [ACC_W-1:0] acc;
   logic                    rd_vld;
   logic [5:0]              rd_k;
   logic [FW-1:0]           fea_sel;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] acc_init;
   logic                    accept;

`ifdef SVM_BIAS_EN
   assign acc_init = bias;
`else
   assign acc_init = '0;
`endif

   always_comb begin
      i_ready = 1'b0;
      case (state)
         IDLE:    i_ready = 1'b1;
         DONE:    i_ready = o_ready;
         default: i_ready = 1'b0;
      endcase
   end

   assign accept  = i_valid && i_ready;
   assign o_valid = (state == DONE);
   assign o_bid   = bid_q;
   assign dot     = acc;

   // Read data lags the address by one cycle, so the feature index is the delayed k.
   always_comb begin
      fea_sel = fea_q[rd_k];
      prod    = PW'(signed'({1'b0, fea_sel})) * PW'(w_rdata);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         bid_q  <= '0;
         acc    <= '0;
         rd_vld <= 1'b0;
         rd_k   <= '0;
         w_ren  <= 1'b0;
         w_addr <= '0;
         for (int j = 0; j < 36; j++) fea_q[j] <= '0;
      end else begin
         rd_vld <= w_ren;
         rd_k   <= w_addr[5:0];
         if (rd_vld) acc <= acc + ACC_W'(prod);
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  for (int j = 0; j < 9; j++) begin
                     fea_q[j]      <= fea_a[(8-j)*FW +: FW];
                     fea_q[9 + j]  <= fea_b[(8-j)*FW +: FW];
                     fea_q[18 + j] <= fea_c[(8-j)*FW +: FW];
                     fea_q[27 + j] <= fea_d[(8-j)*FW +: FW];
                  end
                  bid_q  <= bid;
                  acc    <= acc_init;
                  w_ren  <= 1'b1;
                  w_addr <= {bid, 6'd0};
                  state  <= RUN;
               end else if (state == DONE && o_ready) begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (w_addr[5:0] == 6'd35) begin
                  w_ren <= 1'b0;
                  state <= DRAIN;
               end else begin
                  w_addr[5:0] <= w_addr[5:0] + 6'd1;
               end
            end
            default: state <= DONE;
         endcase
      end
   end

endmodule

// File: tb/tb_svm_block_dot.sv
// tb/tb_svm_block_dot.sv - directed bench for svm_block_dot with a sum-of-products reference model
module tb_svm_block_dot;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [287:0] fea_a = '0, fea_b = '0, fea_c = '0, fea_d = '0;
   logic [12:0] bid = '0;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic        w_ren;
   logic [18:0] w_addr;
   logic [15:0] w_rdata = '0;
   logic [63:0] dot;
   logic [12:0] o_bid;
   logic        o_valid;
   logic        o_ready = 1'b1;

   svm_block_dot dut (
      .clk(clk), .rst(rst),
      .fea_a(fea_a), .fea_b(fea_b), .fea_c(fea_c), .fea_d(fea_d),
      .bid(bid), .i_valid(i_valid), .i_ready(i_ready),
      .w_ren(w_ren), .w_addr(w_addr), .w_rdata(w_rdata),
      .dot(dot), .o_bid(o_bid), .o_valid(o_valid), .o_ready(o_ready)
   );

   always #5 clk = ~clk;

   logic [31:0] fea_m [0:35];
   logic [15:0] wmem  [0:35];

   always @(posedge clk)
      w_rdata <= (w_ren && w_addr[5:0] < 6'd36) ? wmem[w_addr[5:0]] : 16'h0;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_dot();
      longint s = 0;
      for (int k = 0; k < 36; k++)
         s += longint'({32'b0, fea_m[k]}) * longint'(signed'(wmem[k]));
      return s;
   endfunction

   // Reference state: a block is busy from its accept until its result is retired.
   bit          busy = 0;
   int          age = 0;
   logic [63:0] exp_dot = '0;
   logic [12:0] exp_bid = '0;
   logic [63:0] last_dot = '0;
   logic [12:0] last_bid = '0;
   int          nres = 0;
   bit          exp_ready;

   always @(negedge clk) begin
      if (rst) begin
         busy = 0;
         chk("rst_i_ready", i_ready, 1);
         chk("rst_o_valid", o_valid, 0);
         chk("rst_w_ren", w_ren, 0);
         chk("rst_w_addr", w_addr, 0);
         chk("rst_dot", dot, 0);
         chk("rst_o_bid", o_bid, 0);
      end else begin
         if (busy) age++;
         if (!busy) begin
            chk("idle_i_ready", i_ready, 1);
            chk("idle_o_valid", o_valid, 0);
            chk("idle_w_ren", w_ren, 0);
         end else if (age <= 36) begin
            chk("run_w_ren", w_ren, 1);
            chk("run_w_addr", w_addr, {exp_bid, 6'(age - 1)});
            chk("run_i_ready", i_ready, 0);
            chk("run_o_valid", o_valid, 0);
         end else if (age == 37) begin
            chk("drain_w_ren", w_ren, 0);
            chk("drain_i_ready", i_ready, 0);
            chk("drain_o_valid", o_valid, 0);
         end else begin
            chk("done_o_valid", o_valid, 1);
            chk("done_dot", dot, exp_dot);
            chk("done_o_bid", o_bid, exp_bid);
            chk("done_i_ready", i_ready, o_ready);
            chk("done_w_ren", w_ren, 0);
         end
         exp_ready = !busy || (age >= 38 && o_ready);
         if (busy && age >= 38 && o_ready) begin
            last_dot = dot;
            last_bid = o_bid;
            busy = 0;
            nres++;
         end
         if (i_valid && exp_ready) begin
            busy = 1;
            age = 0;
            exp_dot = model_dot();
            exp_bid = bid;
         end
      end
   end

   task automatic pack();
      for (int j = 0; j < 9; j++) begin
         fea_a[(8-j)*32 +: 32] = fea_m[j];
         fea_b[(8-j)*32 +: 32] = fea_m[9 + j];
         fea_c[(8-j)*32 +: 32] = fea_m[18 + j];
         fea_d[(8-j)*32 +: 32] = fea_m[27 + j];
      end
   endtask

   task automatic fill(input logic [31:0] f, input logic [15:0] w);
      for (int k = 0; k < 36; k++) begin
         fea_m[k] = f;
         wmem[k]  = w;
      end
   endtask

   task automatic send(input logic [12:0] b);
      bit ok = 0;
      pack();
      bid = b;
      i_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (i_ready === 1'b1) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1 i_valid = 1'b0;
   endtask

   task automatic wait_nres(input int target);
      bit ok = 0;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         if (nres >= target) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("result_timeout", nres, target);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 1.0 x 1.0 over 36 taps
      fill(32'h1000_0000, 16'h1000);
      send(13'd5);
      chk("model_pin_one", exp_dot, 64'h0000_2400_0000_0000);
      wait_nres(1);
      chk("lit_dot_one", last_dot, 64'h0000_2400_0000_0000);
      chk("lit_bid_one", last_bid, 13'd5);

      // 0.5 x -0.5 over 36 taps
      fill(32'h0800_0000, 16'hF800);
      send(13'd9);
      chk("model_pin_neg", exp_dot, 64'hFFFF_F700_0000_0000);
      wait_nres(2);
      chk("lit_dot_neg", last_dot, 64'hFFFF_F700_0000_0000);

      // mixed data with extremes, stalled consumer, ignored i_valid during RUN and stall
      for (int k = 0; k < 36; k++) begin
         fea_m[k] = 32'h0123_4567 * (k + 1);
         wmem[k]  = 16'h8000 + 16'(k * 16'h0731);
      end
      fea_m[0] = 32'hFFFF_FFFF;
      o_ready = 1'b0;
      send(13'h123);
      repeat (8) @(posedge clk);
      #1 begin i_valid = 1'b1; bid = 13'h1FF; end
      @(posedge clk);
      #1 begin i_valid = 1'b0; bid = 13'h123; end
      for (int n = 0; n < 60; n++) begin
         if (o_valid) break;
         @(posedge clk);
         #1;
      end
      for (int n = 0; n < 5; n++) begin
         i_valid = n[0];
         bid = 13'h1EE;
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;
      chk("stall_no_retire", nres, 2);

      // retire and accept block 7 in the same cycle
      fill(32'h0800_0000, 16'hF800);
      pack();
      bid = 13'd7;
      i_valid = 1'b1;
      o_ready = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      wait_nres(4);
      chk("lit_dot_b2b", last_dot, 64'hFFFF_F700_0000_0000);
      chk("lit_bid_b2b", last_bid, 13'd7);

      // zero features still sweep all 36 addresses
      fill(32'h0, 16'h7FFF);
      send(13'd3);
      wait_nres(5);
      chk("lit_dot_zero", last_dot, 64'h0);

      // reset in the middle of a block, then a clean block
      fill(32'h1000_0000, 16'h1000);
      send(13'd11);
      repeat (18) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_no_result", nres, 5);
      send(13'd12);
      wait_nres(6);
      chk("lit_dot_after_rst", last_dot, 64'h0000_2400_0000_0000);
      chk("lit_bid_after_rst", last_bid, 13'd12);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
